fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
//  Issue/sequencing controller sitting between the core and the shared FPU datapath.
//  - Accepts one FP op at a time over a valid/ready request channel.
//  - Holds operands and opcode stable on the FPU inputs for the op's latency.
//  - Captures the result and returns it with its tag over a valid/ready response channel.
//  - Replaces the FPU-internal fin counter as the single source of completion timing.
// PARAMETERS
//  LAT_ADD   3   cycles for fadd/fsub (op 0000/0001)
//  LAT_MUL   3   cycles for fmul (0010)
//  LAT_DIV   10  cycles for fdiv (0011)
//  LAT_SQRT  8   cycles for fsqrt (0100)
//  TAG_W     5   request/response tag width
// PORTS
//  clk         in   1      clock
//  rstn        in   1      reset, synchronous, active-low
//  req_valid   in   1      request present
//  req_ready   out  1      request accepted when req_valid&req_ready at posedge
//  req_op      in   4      FPU opcode (0000..1010 legal)
//  req_src0    in   32     operand 0
//  req_src1    in   32     operand 1
//  req_tag     in   TAG_W  tag echoed on the response
//  flush       in   1      abort in-flight op, synchronous
//  fpu_op      out  4      opcode to datapath, registered
//  fpu_src0    out  32     operand 0 to datapath, registered
//  fpu_src1    out  32     operand 1 to datapath, registered
//  fpu_result  in   32     datapath result
//  resp_valid  out  1      result available
//  resp_ready  in   1      consumer takes result when resp_valid&resp_ready
//  resp_data   out  32     captured result
//  resp_tag    out  TAG_W  captured tag
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset values: fpu_op=4'b1111, fpu_src0/1=0, resp_valid=0, resp_data=0, resp_tag=0, busy=0.
//    req_ready is 0 while rstn=0.
//  FSM states:
//  - IDLE: waiting for a request.
//  - EXEC: down-counter cnt (4 bits) active.
//  - RESP: resp_valid=1.
//  Combinational ready: req_ready = rstn & ~flush & (IDLE | (RESP & resp_ready)).
//  Accept at edge E0:
//  - Latch op/src/tag into fpu_op/fpu_src0/fpu_src1/tag reg.
//  - Load cnt = LAT(op)-1; go to EXEC.
//  LAT(op) values:
//  - Per parameters for ops 0000..0100.
//  - 1 for ops 0101..1010 (sgnj/sgnjn/sgnjx/feq/fle/flt).
//  - 1 for illegal ops 1011..1111.
//  EXEC:
//  - fpu_* held constant.
//  - cnt decrements each cycle.
//  - In the cycle with cnt==0: capture resp_data = fpu_result (forced to 0 for illegal op) and resp_tag; go to RESP.
//  - Result: resp_valid rises exactly at edge E0+LAT(op).
//  RESP:
//  - resp_valid/resp_data/resp_tag held stable while resp_ready=0.
//  - On handshake: go to IDLE, or to EXEC if a request is accepted the same cycle (back-to-back, no bubble).
//  After completion: fpu_op returns to 4'b1111 in IDLE; fpu_src0/1 keep their last values.
//  Flush, any state: next edge goes to IDLE.
//  - resp_valid=0, in-flight op discarded, no response ever issued for it.
//  - Flush wins over a simultaneous request or handshake; the request is not accepted.
//  rstn low mid-op: identical to flush, plus all outputs return to reset values.
//  Only one op in flight; req_ready=0 for the whole EXEC interval.
// TESTING
//  1. fadd 0x3F800000+0x40000000, tag 5, accepted E0 -> resp_valid at E0+3, data 0x40400000, tag 5.
//  2. fdiv 0x40800000/0x40000000 -> resp_valid at E0+10, data 0x40000000; req_ready=0 during E0+1..E0+10.
//  3. fsqrt 0x41100000 -> resp_valid at E0+8, data 0x40400000; fpu_src0 constant throughout.
//  4. flt 0x3F800000<0x40000000, resp_ready=0 for 4 cycles -> resp_valid/data 0x00000001/tag stable.
//     Then release resp_ready with a fmul pending -> handshake and accept on the same edge; mul result at +3.
//  5. fdiv, flush in 5th EXEC cycle -> IDLE next cycle, resp_valid never rises, req_ready=1 afterwards.
//  6. op 4'b1100, tag 31 -> resp_valid at E0+1, data 0, tag 31.
//     rstn pulsed during fmul EXEC -> all outputs at reset values, no response.

Source files
------------

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response channel between the core and the FPU issue controller.
// Both channels use valid/ready: a transfer happens on the rising clk edge
// where valid and ready are both 1. Once raised, valid and its payload stay
// stable until that transfer.
//   req_*  : core -> controller (req_ready flows back)
//   resp_* : controller -> core (resp_ready flows back)
// master = core side, slave = controller side.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_src0;
  logic [31:0]      req_src1;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_src0, req_src1, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_src0, req_src1, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one FP op at a time, holds its opcode and
// operands on the shared datapath for the op's latency, captures the result
// and returns it with the request tag. It is the only source of completion
// timing for the datapath.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   flush          abort any in-flight op (synchronous, wins over everything)
//   bus            request/response channels (slave side)
//   fpu_op/src0/1  registered opcode and operands to the datapath
//   fpu_result     datapath result, sampled on the op's final cycle
//   busy           controller not idle
//   dbg_state      current FSM state
module fpu_issue_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 8,
  parameter int TAG_W    = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  fpu_issue_ctrl_if.slave bus,
  output logic [3:0]   fpu_op,
  output logic [31:0]  fpu_src0,
  output logic [31:0]  fpu_src1,
  input  logic [31:0]  fpu_result,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;
  logic             accept;

  // Latency minus one, i.e. the value loaded into the down-counter.
  // Single-cycle ops and illegal opcodes share the default.
  function automatic logic [3:0] lat_m1(input logic [3:0] op);
    case (op)
      4'h0, 4'h1: lat_m1 = 4'(LAT_ADD - 1);
      4'h2:       lat_m1 = 4'(LAT_MUL - 1);
      4'h3:       lat_m1 = 4'(LAT_DIV - 1);
      4'h4:       lat_m1 = 4'(LAT_SQRT - 1);
      default:    lat_m1 = 4'd0;
    endcase
  endfunction

  // A new op may enter while idle, or in the same cycle the pending
  // response is consumed, so back-to-back ops have no bubble.
  assign bus.req_ready  = rstn & ~flush &
                          ((state_q == IDLE) | ((state_q == RESP) & bus.resp_ready));
  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.resp_valid = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (bus.resp_ready) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      tag_q         <= '0;
      illegal_q     <= 1'b0;
      fpu_op        <= 4'hF;
      fpu_src0      <= 32'd0;
      fpu_src1      <= 32'd0;
      bus.resp_data <= 32'd0;
      bus.resp_tag  <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        fpu_op <= 4'hF;
      end else if (accept) begin
        fpu_op    <= bus.req_op;
        fpu_src0  <= bus.req_src0;
        fpu_src1  <= bus.req_src1;
        tag_q     <= bus.req_tag;
        illegal_q <= (bus.req_op > 4'hA);
        cnt_q     <= lat_m1(bus.req_op);
      end else begin
        if (state_q == EXEC) begin
          if (cnt_q == 4'd0) begin
            bus.resp_data <= illegal_q ? 32'd0 : fpu_result;
            bus.resp_tag  <= tag_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // Response consumed with nothing new behind it: park the datapath.
        if ((state_q == RESP) && bus.resp_ready) fpu_op <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;
  localparam int TAG_W = 5;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_src0;
  logic [31:0] fpu_src1;
  logic [31:0] fpu_result;
  logic        busy;
  logic [1:0]  dbg_state;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpu_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .bus        (bus.slave),
    .fpu_op     (fpu_op),
    .fpu_src0   (fpu_src0),
    .fpu_src1   (fpu_src1),
    .fpu_result (fpu_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath stand-in ----------------
  // Known FP cases return the true IEEE result; anything else gets a hash
  // that depends on opcode and both operands.
  function automatic logic [31:0] fake_fpu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    if (op == 4'h0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 4'h3 && a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
    if (op == 4'h4 && a == 32'h41100000)                      return 32'h40400000;
    if (op == 4'hA && a == 32'h3F800000 && b == 32'h40000000) return 32'h00000001;
    if (op == 4'h2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {28'd0, op} ^ 32'h5A5A0000;
  endfunction

  assign fpu_result = fake_fpu(fpu_op, fpu_src0, fpu_src1);

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2: return 3;
      4'h3:             return 10;
      4'h4:             return 8;
      default:          return 1;
    endcase
  endfunction

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  int now = 0;                      // rising edges seen by the model
  logic [31:0]      exp_q[$];       // expected response data
  logic [TAG_W-1:0] tag_q[$];       // expected response tag
  logic [3:0]       op_q[$];        // opcode of the op in flight
  int               due_q[$];       // edge at which resp_valid must be up
  logic [31:0]      m_src0 = 32'd0;
  logic [31:0]      m_src1 = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, check ready, advance model.
  task automatic step(input bit rv, input logic [3:0] op, input logic [31:0] s0,
                      input logic [31:0] s1, input logic [TAG_W-1:0] tg,
                      input bit rr, input bit fl, input bit rn);
    bit m_valid, m_ready, m_busy;
    @(negedge clk);
    m_busy  = (exp_q.size() != 0);
    m_valid = m_busy && (now >= due_q[0]);
    check("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
    if (m_valid) begin
      check("resp_data", bus.resp_data, exp_q[0]);
      check("resp_tag", 32'(bus.resp_tag), 32'(tag_q[0]));
    end
    check("busy", 32'(busy), 32'(m_busy));
    check("fpu_op", 32'(fpu_op), m_busy ? 32'(op_q[0]) : 32'hF);
    check("fpu_src0", fpu_src0, m_src0);
    check("fpu_src1", fpu_src1, m_src1);

    bus.req_valid  = rv;
    bus.req_op     = op;
    bus.req_src0   = s0;
    bus.req_src1   = s1;
    bus.req_tag    = tg;
    bus.resp_ready = rr;
    flush          = fl;
    rstn           = rn;
    #1;
    m_ready = rn && !fl && (!m_busy || (m_valid && rr));
    check("req_ready", 32'(bus.req_ready), 32'(m_ready));

    now++;
    if (!rn || fl) begin
      exp_q.delete(); tag_q.delete(); op_q.delete(); due_q.delete();
      if (!rn) begin
        m_src0 = 32'd0;
        m_src1 = 32'd0;
      end
    end else begin
      if (m_valid && rr) begin
        void'(exp_q.pop_front()); void'(tag_q.pop_front());
        void'(op_q.pop_front());  void'(due_q.pop_front());
      end
      if (rv && m_ready) begin
        exp_q.push_back((op > 4'hA) ? 32'd0 : fake_fpu(op, s0, s1));
        tag_q.push_back(tg);
        op_q.push_back(op);
        due_q.push_back(now + lat_of(op));
        m_src0 = s0;
        m_src1 = s1;
      end
    end
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'd0, 32'd0, '0, rr, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [TAG_W-1:0] tg, input bit rr);
    step(1'b1, op, s0, s1, tg, rr, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 4'h0;
    bus.req_src0 = 32'd0;
    bus.req_src1 = 32'd0;
    bus.req_tag = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state is checked by the first step.
    idle(2, 1'b1);

    // fadd, tag 5: response three edges after acceptance.
    issue(4'h0, 32'h3F800000, 32'h40000000, 5'd5, 1'b1);
    idle(5, 1'b1);

    // fdiv: ten-cycle latency, request side blocked meanwhile.
    issue(4'h3, 32'h40800000, 32'h40000000, 5'd2, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b1, 4'h1, 32'h1, 32'h2, 5'd9, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // fsqrt with operand held for the whole execution.
    issue(4'h4, 32'h41100000, 32'h0, 5'd3, 1'b1);
    idle(10, 1'b1);

    // flt with consumer stalled, then back-to-back fmul on release.
    issue(4'hA, 32'h3F800000, 32'h40000000, 5'd7, 1'b0);
    idle(5, 1'b0);
    issue(4'h2, 32'h40000000, 32'h40400000, 5'd8, 1'b1);
    idle(5, 1'b1);

    // fdiv aborted by flush in its 5th execution cycle.
    issue(4'h3, 32'h40800000, 32'h40000000, 5'd4, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 4'h0, 32'h1, 32'h2, 5'd1, 1'b1, 1'b1, 1'b1);
    idle(12, 1'b1);

    // Illegal op, tag 31: single-cycle, zero data.
    issue(4'hC, 32'hDEADBEEF, 32'h12345678, 5'd31, 1'b1);
    idle(3, 1'b1);

    // Reset pulsed while an fmul executes.
    issue(4'h2, 32'h11111111, 32'h22222222, 5'd6, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 4'h0, 32'h3, 32'h4, 5'd1, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r_op;
      logic [31:0] r_s0, r_s1;
      logic [TAG_W-1:0] r_tag;
      bit r_rv, r_rr, r_fl, r_rn;
      r_op  = 4'($urandom_range(0, 15));
      r_s0  = $urandom;
      r_s1  = $urandom;
      r_tag = TAG_W'($urandom_range(0, 31));
      r_rv  = ($urandom_range(0, 99) < 50);
      r_rr  = ($urandom_range(0, 99) < 70);
      r_fl  = ($urandom_range(0, 99) < 3);
      r_rn  = ($urandom_range(0, 99) >= 1);
      step(r_rv, r_op, r_s0, r_s1, r_tag, r_rr, r_fl, r_rn);
    end
    idle(15, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
